seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Multiplexed scan driver for the 3-digit min:sec display. It sits directly downstream of the 7-segment counter stage and consumes that stage's three 8-bit segment patterns. It time-multiplexes the patterns onto one shared segment bus with one-hot active-low digit enables. It also provides ghost-suppression guard time, 16-level brightness PWM, minute-digit zero blanking and a decimal-point overlay.

## Interface
- SCAN_DIV, 1040: clk cycles per digit slot; (SCAN_DIV-GUARD) must be a nonzero multiple of 16
- GUARD, 16: cycles at slot start with all digits off; must be >= 1 and < SCAN_DIV
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- en  in  1  scan enable; 0 = display dark
- seg0  in  8  seconds-units pattern, bit7=a … bit1=g, bit0=dp
- seg1  in  8  seconds-tens pattern, same encoding
- seg2  in  8  minutes pattern, same encoding
- bright  in  4  brightness, 0 = dimmest, 15 = full on-window
- blank_lz  in  1  1 = suppress digit 2 when its snapshot equals 8'b11111100 ("0")
- dp_mask  in  3  bit i forces dp (bit0) on for digit i
- seg_out  out  8  shared segment bus, active-high, same encoding as inputs
- an  out  3  digit enables, active-low one-hot; an[i] drives digit i
- frame_tick  out  1  one-cycle pulse on the last cycle of each completed frame

## Operation
- States: IDLE, DIG0, DIG1, DIG2. Slot counter cnt runs 0..SCAN_DIV-1 and is clog2(SCAN_DIV) bits wide.
- IDLE: seg_out=0, an=3'b111, cnt=0. With en=1 the next edge enters DIG0 with cnt=0.
- DIGi: cnt increments each cycle. At cnt=SCAN_DIV-1 the state advances DIG0→DIG1→DIG2→DIG0 and cnt returns to 0.
- Snapshot: seg0..seg2, blank_lz and dp_mask are latched into snap registers on every entry to DIG0 (from IDLE or wrap). Inputs do not affect the frame in progress, so there is no tearing.
- seg_out in DIGi = snap_seg[i] | {7'b0, snap_dp[i]}. It is driven for the whole slot, guard included.
- On-window: step = (SCAN_DIV-GUARD)>>4 and on_len = step*(bright+1). bright is sampled live each cycle.
- an[i]=0 only when state=DIGi, GUARD <= cnt < GUARD+on_len, and the digit is not blanked. Otherwise an[i]=1.
- Blanking applies only to digit 2: snap_blank_lz=1 and snap_seg[2]==8'b11111100. The comparison ignores dp_mask. seg_out still carries the pattern; only an[2] stays high.
- frame_tick=1 exactly when state=DIG2 and cnt=SCAN_DIV-1 and en=1.
- en=0 in any DIGi: the next edge enters IDLE and outputs go dark. No partial-frame frame_tick is issued.
- rst=1 has priority over everything: IDLE, cnt=0, snap registers cleared, outputs as in reset.

## Timing
- Reset values: seg_out=8'h00, an=3'b111, frame_tick=0, state IDLE.
- All outputs are registered and update on the same edge as state and cnt.
- Output at cycle k is a function of state, cnt and snap registers after edge k. There is no additional pipeline offset.
- en rises: edge 1 enters DIG0 with cnt=0 and latches the snapshot. The first an[0]=0 appears GUARD edges later.
- Frame length is 3*SCAN_DIV cycles. frame_tick period is 3*SCAN_DIV while en=1.
- Input change latency to display is at most 3*SCAN_DIV cycles, i.e. the next DIG0 entry.
- No two an bits are ever low simultaneously. an is always high for at least GUARD cycles between consecutive digits.

## Test plan
All scenarios use SCAN_DIV=36 and GUARD=4, so step=2 and the frame is 108 cycles.

1. Reset and enable: hold rst 3 cycles, then rst=0 and en=1 with seg0=8'hFC, seg1=8'h60, seg2=8'hDA, bright=15.
   - Outputs must read 00/111/0 during rst.
   - DIG0 is seg_out=FC with an=110 for cnt 4..35. DIG1 is 60 with an=101. DIG2 is DA with an=011.
   - frame_tick pulses once per 108 cycles.
2. Brightness: bright=0 → an low only at cnt 4..5 of each slot. bright=7 → cnt 4..19. Verify an=111 at cnt 0..3 and after the window.
3. Snapshot: change seg1 from 60 to B6 at cnt 10 of DIG0. The DIG1 slot of the same frame must still show 60. The next frame shows B6.
4. Blanking and dp: seg2=8'hFC, blank_lz=1 → an[2] never low, seg_out=FC in DIG2.
   - With dp_mask=3'b100 and seg2=60 → seg_out=61 in DIG2.
   - With blank_lz=0 and seg2=FC → an[2] is low normally.
5. Mid-frame disable and reset: en=0 at cnt 20 of DIG1 → next cycle IDLE, an=111, seg_out=00, no frame_tick.
   - Re-enable → DIG0 with a fresh snapshot.
   - rst at cnt 30 of DIG2 → reset values next cycle and no frame_tick.
6. Exclusivity: run 10 frames with random seg inputs, bright and dp_mask. Assert that an is never zero-hot-violating, that at most one bit is low, and that the guard is honoured on every slot.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Multiplexed 3-digit 7-segment scan driver: per-frame snapshot, guard time,
// 16-level brightness window, minute-digit zero blanking and dp overlay.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 1040,
  parameter int unsigned GUARD    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [3:0] bright,
  input  logic       blank_lz,
  input  logic [2:0] dp_mask,
  output logic [7:0] seg_out,
  output logic [2:0] an,
  output logic       frame_tick
);

  localparam int unsigned CW   = $clog2(SCAN_DIV);
  localparam int unsigned STEP = (SCAN_DIV - GUARD) >> 4;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, DIG0, DIG1, DIG2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    snap0_q, snap0_d, snap1_q, snap1_d, snap2_q, snap2_d;
  logic          blank_q, blank_d;
  logic [2:0]    dp_q, dp_d;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;
  logic          tick_q, tick_d;

  logic          take_snap;
  logic          in_window;
  logic          blanked;
  int unsigned   on_len;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    take_snap = 1'b0;
    if (state_q == IDLE) begin
      if (en) begin
        state_d   = DIG0;
        cnt_d     = '0;
        take_snap = 1'b1;
      end
    end else if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      case (state_q)
        DIG0:    state_d = DIG1;
        DIG1:    state_d = DIG2;
        default: begin
          state_d   = DIG0;
          take_snap = 1'b1;
        end
      endcase
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    snap0_d = snap0_q;
    snap1_d = snap1_q;
    snap2_d = snap2_q;
    blank_d = blank_q;
    dp_d    = dp_q;
    if (take_snap) begin
      snap0_d = seg0;
      snap1_d = seg1;
      snap2_d = seg2;
      blank_d = blank_lz;
      dp_d    = dp_mask;
    end
  end

  // Outputs are computed from next-state values so the registered outputs
  // line up with state/cnt on the same edge, with no extra pipeline stage.
  always_comb begin
    seg_d     = '0;
    an_d      = '1;
    tick_d    = 1'b0;
    on_len    = STEP * (32'(bright) + 32'd1);
    in_window = (32'(cnt_d) >= GUARD) && (32'(cnt_d) < GUARD + on_len);
    blanked   = blank_d && (snap2_d == 8'hFC);
    case (state_d)
      DIG0: begin
        seg_d = snap0_d | {7'b0, dp_d[0]};
        an_d  = in_window ? 3'b110 : 3'b111;
      end
      DIG1: begin
        seg_d = snap1_d | {7'b0, dp_d[1]};
        an_d  = in_window ? 3'b101 : 3'b111;
      end
      DIG2: begin
        seg_d  = snap2_d | {7'b0, dp_d[2]};
        an_d   = (in_window && !blanked) ? 3'b011 : 3'b111;
        tick_d = (cnt_d == LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap0_q <= '0;
      snap1_q <= '0;
      snap2_q <= '0;
      blank_q <= 1'b0;
      dp_q    <= '0;
      seg_q   <= '0;
      an_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap0_q <= snap0_d;
      snap1_q <= snap1_d;
      snap2_q <= snap2_d;
      blank_q <= blank_d;
      dp_q    <= dp_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      tick_q  <= tick_d;
    end
  end

  assign seg_out    = seg_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a frame-position reference model queues
// per-cycle expectations; an independent monitor pops and compares them.
module tb_seg_scan_driver;

  localparam int SD    = 36;
  localparam int G     = 4;
  localparam int STEP  = (SD - G) / 16;
  localparam int FRAME = 3 * SD;

  logic       clk = 1'b0;
  logic       rst, en, blank_lz;
  logic [7:0] seg0, seg1, seg2;
  logic [3:0] bright;
  logic [2:0] dp_mask;
  logic [7:0] seg_out;
  logic [2:0] an;
  logic       frame_tick;

  seg_scan_driver #(.SCAN_DIV(SD), .GUARD(G)) dut (
    .clk(clk), .rst(rst), .en(en), .seg0(seg0), .seg1(seg1), .seg2(seg2),
    .bright(bright), .blank_lz(blank_lz), .dp_mask(dp_mask),
    .seg_out(seg_out), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] seg;
    logic [2:0] an;
    logic       tick;
  } exp_t;

  exp_t expq[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: position within the frame since the last DIG0 entry.
  bit         m_active = 0;
  int         m_pos    = 0;
  logic [7:0] m_snap[3];
  logic       m_blank;
  logic [2:0] m_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic take_snap();
    m_snap[0] = seg0;
    m_snap[1] = seg1;
    m_snap[2] = seg2;
    m_blank   = blank_lz;
    m_dp      = dp_mask;
  endtask

  // Predict outputs after the coming rising edge from the inputs now applied.
  task automatic cyc();
    exp_t e;
    int   d, c, onlen;
    bit   lit;
    if (rst) begin
      m_active = 0;
      m_pos    = 0;
    end else if (!m_active) begin
      if (en) begin
        m_active = 1;
        m_pos    = 0;
        take_snap();
      end
    end else if (!en) begin
      m_active = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      if (m_pos == 0) take_snap();
    end
    if (!m_active) begin
      e.seg = 8'h00; e.an = 3'b111; e.tick = 1'b0;
    end else begin
      d     = m_pos / SD;
      c     = m_pos % SD;
      onlen = STEP * (int'(bright) + 1);
      lit   = (c >= G) && (c < G + onlen) && !(d == 2 && m_blank && m_snap[2] == 8'hFC);
      e.seg  = m_snap[d] | {7'b0, m_dp[d]};
      e.an   = lit ? ~(3'b001 << d) : 3'b111;
      e.tick = (d == 2) && (c == SD - 1);
    end
    expq.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_to(input int d, input int c);
    int n = 0;
    while (!(m_active && m_pos == d * SD + c) && n < 4 * FRAME) begin
      cyc();
      n++;
    end
    chk("run_to_reached", {31'b0, m_active && m_pos == d * SD + c}, 32'd1);
  endtask

  // Monitor: compares queued expectations and checks digit exclusivity/guard.
  int last_dig = -1;
  int high_run = 0;
  always begin : mon
    exp_t e;
    int   ld;
    @(posedge clk);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("seg_out", {24'b0, seg_out}, {24'b0, e.seg});
      chk("an", {29'b0, an}, {29'b0, e.an});
      chk("frame_tick", {31'b0, frame_tick}, {31'b0, e.tick});
      chk("an_at_most_one_low", {31'b0, $countones(~an) <= 1}, 32'd1);
      if (an != 3'b111) begin
        ld = !an[0] ? 0 : (!an[1] ? 1 : 2);
        if (last_dig >= 0 && ld != last_dig)
          chk("guard_between_digits", {31'b0, high_run >= G}, 32'd1);
        last_dig = ld;
        high_run = 0;
      end else begin
        high_run++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; en = 0; seg0 = 8'hFC; seg1 = 8'h60; seg2 = 8'hDA;
    bright = 4'd15; blank_lz = 0; dp_mask = 3'b000;
    @(negedge clk);

    // Reset, then enable at full brightness
    run(3);
    rst = 0; en = 1;
    run(2 * FRAME);

    // Brightness extremes and mid-range
    bright = 4'd0;
    run(FRAME);
    bright = 4'd7;
    run(FRAME);
    bright = 4'd15;

    // Snapshot: seg1 change during DIG0 must wait for the next frame
    run_to(0, 9);
    seg1 = 8'hB6;
    run(2 * FRAME);

    // Zero blanking, dp overlay, blanking disabled
    seg2 = 8'hFC; blank_lz = 1;
    run(2 * FRAME);
    seg2 = 8'h60; dp_mask = 3'b100;
    run(2 * FRAME);
    seg2 = 8'hFC; blank_lz = 0; dp_mask = 3'b000;
    run(2 * FRAME);

    // Mid-frame disable, re-enable with fresh values, reset mid-DIG2
    run_to(1, 19);
    en = 0;
    run(5);
    en = 1; seg0 = 8'h0A; seg1 = 8'hEE; seg2 = 8'h3E;
    run(FRAME + 10);
    run_to(2, 29);
    rst = 1;
    run(2);
    rst = 0;
    run(FRAME);

    // Randomized frames
    for (int i = 0; i < 10 * FRAME; i++) begin
      if ($urandom_range(19) == 0) begin
        seg0     = 8'($urandom);
        seg1     = 8'($urandom);
        seg2     = ($urandom_range(2) == 0) ? 8'hFC : 8'($urandom);
        dp_mask  = 3'($urandom);
        blank_lz = 1'($urandom);
      end
      if ($urandom_range(49) == 0) bright = 4'($urandom);
      cyc();
    end

    en = 0;
    run(3);
    @(posedge clk);
    #2;
    chk("queue_drained", expq.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
